// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state type and helpers shared by the ALU execution stage
package alu_pkg;

    localparam int ALUOP_W = 5;

    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 5'b00000;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 5'b00001;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 5'b00010;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 5'b10010;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 5'b00011;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 5'b00100;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU = 5'b00101;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL  = 5'b00110;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL  = 5'b00111;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA  = 5'b01000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    // Shifts are the only ops that run on the iterative datapath.
    function automatic logic is_shift(input logic [ALUOP_W-1:0] op);
        return (op == ALUOP_SRL) || (op == ALUOP_SLL) || (op == ALUOP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - combinational single-cycle logic/arithmetic ops
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    // Select the single-cycle result; shifts and unknown codes give zero here.
    always_comb begin
        result = '0;
        case (aluop)
            ALUOP_AND:  result = a & b;
            ALUOP_OR:   result = a | b;
            ALUOP_ADD:  result = a + b;
            ALUOP_SUB:  result = a - b;
            ALUOP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            ALUOP_XOR:  result = a ^ b;
            ALUOP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU stage with one-bit-per-cycle shifter
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [4:0]         aluop_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o,
    output logic               zero_o
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t           state;
    alu_state_t           state_next;
    logic [WIDTH-1:0]     work;
    logic [WIDTH-1:0]     shifted;
    logic [SHW-1:0]       count;
    logic [ALUOP_W-1:0]   op;
    logic [WIDTH-1:0]     core_result;
    logic [WIDTH-1:0]     quick_result;
    logic                 accept;
    logic                 go_shift;
    logic                 last_shift;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .aluop  (aluop_i),
        .a      (a_i),
        .b      (b_i),
        .result (core_result)
    );

    // Starts are only taken when idle or completing, which allows back-to-back issue.
    assign accept     = start_i && ((state == IDLE) || (state == DONE));
    assign go_shift   = accept && is_shift(aluop_i) && (b_i[SHW-1:0] != '0);
    assign last_shift = (state == SHIFT) && (count == SHW'(1));

    // A zero-amount shift completes immediately and simply passes operand A through.
    assign quick_result = is_shift(aluop_i) ? a_i : core_result;

    // One-bit step of the working register according to the latched shift op.
    always_comb begin
        shifted = work;
        case (op)
            ALUOP_SRL: shifted = {1'b0, work[WIDTH-1:1]};
            ALUOP_SLL: shifted = {work[WIDTH-2:0], 1'b0};
            ALUOP_SRA: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            default:   shifted = work;
        endcase
    end

    // Next-state selection for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = go_shift ? SHIFT : DONE;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = accept ? (go_shift ? SHIFT : DONE) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift datapath, counter and the result/zero registers that load only on entry to DONE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            work     <= '0;
            count    <= '0;
            op       <= '0;
            result_o <= '0;
            zero_o   <= 1'b1;
        end else if (go_shift) begin
            work  <= a_i;
            count <= b_i[SHW-1:0];
            op    <= aluop_i;
        end else if (accept) begin
            result_o <= quick_result;
            zero_o   <= (quick_result == '0);
        end else if (state == SHIFT) begin
            work  <= shifted;
            count <= count - SHW'(1);
            if (last_shift) begin
                result_o <= shifted;
                zero_o   <= (shifted == '0);
            end
        end
    end

    assign busy_o = (state == SHIFT);
    assign done_o = (state == DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [4:0]  aluop_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .aluop_i  (aluop_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op for a single cycle, then run until done (bounded); returns busy count and latency.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output int lat);
        nbusy = 0;
        lat   = 0;
        aluop_i = op; a_i = a; b_i = b; start_i = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) begin
                start_i = 1'b0;
                a_i = ~a;
                b_i = ~b;
            end
            if (busy_o) nbusy++;
            if (done_o) begin
                lat = i;
                break;
            end
        end
    endtask

    int nb;
    int lt;
    int ndone;
    logic [31:0] cap;

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; aluop_i = '0; a_i = '0; b_i = '0;
        tick(); tick();
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", {31'b0, zero_o}, 32'd1);
        rst_ni = 1'b1;
        tick();

        // ADD 5+7
        run_op(5'b00010, 32'd5, 32'd7, nb, lt);
        chk("add_lat", lt, 1);
        chk("add_busy", nb, 0);
        chk("add_result", result_o, 32'd12);
        chk("add_zero", {31'b0, zero_o}, 32'd0);
        tick();
        chk("add_done_drop", {31'b0, done_o}, 32'd0);
        chk("add_hold", result_o, 32'd12);

        // Back-to-back SUB, SLT, SLTU with start held high
        aluop_i = 5'b10010; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
        tick();
        chk("sub_done", {31'b0, done_o}, 32'd1);
        chk("sub_result", result_o, 32'hFFFF_FFFE);
        aluop_i = 5'b00011; a_i = 32'hFFFF_FFFF; b_i = 32'd1;
        tick();
        chk("slt_done", {31'b0, done_o}, 32'd1);
        chk("slt_result", result_o, 32'd1);
        chk("slt_zero", {31'b0, zero_o}, 32'd0);
        aluop_i = 5'b00101;
        tick();
        chk("sltu_done", {31'b0, done_o}, 32'd1);
        chk("sltu_result", result_o, 32'd0);
        chk("sltu_zero", {31'b0, zero_o}, 32'd1);
        aluop_i = 5'b00100; a_i = 32'hF0F0_00FF; b_i = 32'h0FF0_0F0F;
        tick();
        chk("xor_result", result_o, 32'hFF00_0FF0);
        start_i = 1'b0;
        tick();
        chk("b2b_idle", {31'b0, done_o}, 32'd0);

        // SLL 1<<4
        run_op(5'b00111, 32'd1, 32'd4, nb, lt);
        chk("sll4_busy", nb, 4);
        chk("sll4_lat", lt, 5);
        chk("sll4_result", result_o, 32'h10);

        // Zero-amount shift passes A through
        run_op(5'b00110, 32'h0000_ABCD, 32'h0000_0100, nb, lt);
        chk("sh0_lat", lt, 1);
        chk("sh0_busy", nb, 0);
        chk("sh0_result", result_o, 32'h0000_ABCD);

        // Maximum-length shifts
        run_op(5'b01000, 32'h8000_0000, 32'd31, nb, lt);
        chk("sra31_busy", nb, 31);
        chk("sra31_lat", lt, 32);
        chk("sra31_result", result_o, 32'hFFFF_FFFF);
        run_op(5'b00110, 32'h8000_0000, 32'd31, nb, lt);
        chk("srl31_lat", lt, 32);
        chk("srl31_result", result_o, 32'h0000_0001);
        tick();

        // Start during SHIFT is ignored
        aluop_i = 5'b00111; a_i = 32'h0000_00A5; b_i = 32'd8; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("ign_busy", {31'b0, busy_o}, 32'd1);
        tick(); tick();
        aluop_i = 5'b00010; a_i = 32'd5; b_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ndone = 0;
        cap = '0;
        for (int i = 0; i < 14; i++) begin
            if (done_o) begin
                ndone++;
                cap = result_o;
            end
            tick();
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_result", cap, 32'h0000_A500);
        chk("ign_idle", {31'b0, done_o}, 32'd0);

        // Reset mid-shift, with a simultaneous start
        aluop_i = 5'b00111; a_i = 32'd1; b_i = 32'd20; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        rst_ni = 1'b0; start_i = 1'b1; aluop_i = 5'b00010;
        tick();
        chk("rstmid_busy", {31'b0, busy_o}, 32'd0);
        chk("rstmid_done", {31'b0, done_o}, 32'd0);
        chk("rstmid_result", result_o, 32'd0);
        chk("rstmid_zero", {31'b0, zero_o}, 32'd1);
        rst_ni = 1'b1; start_i = 1'b0;
        tick();
        chk("rstmid_after", {31'b0, done_o}, 32'd0);

        // Nonzero result, then unknown opcode clears it
        run_op(5'b00001, 32'h0000_1200, 32'h0000_0034, nb, lt);
        chk("or_result", result_o, 32'h0000_1234);
        run_op(5'b11111, 32'hFFFF_FFFF, 32'd1, nb, lt);
        chk("unk_lat", lt, 1);
        chk("unk_result", result_o, 32'd0);
        chk("unk_zero", {31'b0, zero_o}, 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
